commit_trace_packer: RTL and testbench

- Hardware producer of the commit trace that the processor bench currently reconstructs externally.
- Captures per-cycle writeback, load, store and halt events from the pipeline's final stages.
- Buffers the events in a small FIFO and serializes each one into 16-bit words on a valid/ready stream.
- The stream feeds an on-chip trace port or a bench-side consumer, which rebuilds REG/LOAD/STORE lines from it.

---
 rtl/commit_trace_packer.sv | 202 ++++++++++++++++++++
 tb/tb_commit_trace_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_packer.sv
// Commit trace packer: queues per-cycle commit events and serializes each as 1-4 16-bit words.
// Optional macro TRACE_CYCLE_STAMP_EN adds a 16-bit cycle stamp word right after the header.
`timescale 1ns/1ps
module commit_trace_packer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_wr,
    input  logic [2:0]       reg_idx,
    input  logic [15:0]      reg_data,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_rdata,
    input  logic [15:0]      mem_wdata,
    input  logic             halt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_last,
    output logic [15:0]      drop_count,
    output logic [CNT_W-1:0] fifo_count,
    output logic             done
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
`ifdef TRACE_CYCLE_STAMP_EN
        S_STAMP,
`endif
        S_REGD,
        S_ADDR,
        S_MDATA
    } state_t;

    logic [15:0] r_hdr_mem  [DEPTH];
    logic [15:0] r_regd_mem [DEPTH];
    logic [15:0] r_addr_mem [DEPTH];
    logic [15:0] r_mdat_mem [DEPTH];
`ifdef TRACE_CYCLE_STAMP_EN
    logic [15:0] r_stamp_mem [DEPTH];
    logic [15:0] r_cycle;
`endif

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_seq;
    logic             r_lost;
    logic             r_cap_en;
    logic             r_halt_dropped;
    logic [15:0]      r_drop_count;
    logic             r_done;
    logic             r_valid;
    state_t           r_state;

    logic             w_event;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic [15:0]      w_hdr_new;
    logic [15:0]      w_mval;
    logic [15:0]      w_head_hdr;
    logic             w_head_rw;
    logic             w_head_mem;
    logic             w_accept;
    logic             w_last;
    logic             w_pop;
    logic [15:0]      w_data;
    state_t           w_after;
    state_t           w_next;

    // Fullness uses pre-edge occupancy, so a same-cycle pop never rescues a push.
    always_comb begin
        w_event   = r_cap_en & (reg_wr | mem_rd | mem_wr | halt);
        w_full    = (r_count == CNT_W'(DEPTH));
        w_push    = w_event & ~w_full;
        w_drop    = w_event & w_full;
        w_mval    = mem_wr ? mem_wdata : mem_rdata;
        w_hdr_new = {halt, mem_wr, mem_rd & ~mem_wr, reg_wr,
                     reg_wr ? reg_idx : 3'd0, r_lost, r_seq};
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_hdr_mem[r_wr_ptr]  <= w_hdr_new;
            r_regd_mem[r_wr_ptr] <= reg_data;
            r_addr_mem[r_wr_ptr] <= mem_addr;
            r_mdat_mem[r_wr_ptr] <= w_mval;
`ifdef TRACE_CYCLE_STAMP_EN
            r_stamp_mem[r_wr_ptr] <= r_cycle;
`endif
        end
    end

    // Word sequencing: the state names the word currently presented on the stream.
    always_comb begin
        w_head_hdr = r_hdr_mem[r_rd_ptr];
        w_head_rw  = w_head_hdr[12];
        w_head_mem = w_head_hdr[14] | w_head_hdr[13];
        w_after    = S_IDLE;
        w_data     = 16'h0000;
        case (r_state)
            S_HDR: begin
                w_data = w_head_hdr;
`ifdef TRACE_CYCLE_STAMP_EN
                w_after = S_STAMP;
            end
            S_STAMP: begin
                w_data = r_stamp_mem[r_rd_ptr];
`endif
                if (w_head_rw)       w_after = S_REGD;
                else if (w_head_mem) w_after = S_ADDR;
            end
            S_REGD: begin
                w_data = r_regd_mem[r_rd_ptr];
                if (w_head_mem) w_after = S_ADDR;
            end
            S_ADDR: begin
                w_data  = r_addr_mem[r_rd_ptr];
                w_after = S_MDATA;
            end
            S_MDATA: w_data = r_mdat_mem[r_rd_ptr];
            default: w_data = 16'h0000;
        endcase
        w_last   = (r_state != S_IDLE) && (w_after == S_IDLE);
        w_accept = r_valid & out_ready;
        w_pop    = w_accept & w_last;
    end

    // After a record ends, go straight to the next header when anything remains queued.
    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE) begin
            if ((r_count != '0) || w_push) w_next = S_HDR;
        end else if (w_accept) begin
            if (!w_last)                                      w_next = w_after;
            else if ((r_count > CNT_W'(1)) || w_push)         w_next = S_HDR;
            else                                              w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_seq          <= 8'd0;
            r_lost         <= 1'b0;
            r_cap_en       <= 1'b1;
            r_halt_dropped <= 1'b0;
            r_drop_count   <= 16'd0;
            r_done         <= 1'b0;
            r_valid        <= 1'b0;
            r_state        <= S_IDLE;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next != S_IDLE);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_seq    <= r_seq + 8'd1;
                r_lost   <= 1'b0;
            end
            if (w_drop) begin
                r_lost <= 1'b1;
                if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
                if (halt) r_halt_dropped <= 1'b1;
            end
            if (w_event && halt) r_cap_en <= 1'b0;
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A dropped halt completes once the queue has fully drained.
            if ((w_pop && w_head_hdr[15]) ||
                (r_halt_dropped && ((r_count == '0) || (w_pop && (r_count == CNT_W'(1))))))
                r_done <= 1'b1;
        end
    end

`ifdef TRACE_CYCLE_STAMP_EN
    always_ff @(posedge clk) begin
        if (rst) r_cycle <= 16'd0;
        else     r_cycle <= r_cycle + 16'd1;
    end
`endif

    assign out_valid  = r_valid;
    assign out_data   = w_data;
    assign out_last   = w_last;
    assign drop_count = r_drop_count;
    assign fifo_count = r_count;
    assign done       = r_done;

endmodule

// File: tb/tb_commit_trace_packer.sv
// Directed bench for commit_trace_packer (default build) with a word-level scoreboard.
`timescale 1ns/1ps
module tb_commit_trace_packer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             reg_wr, mem_rd, mem_wr, halt, out_ready;
    logic [2:0]       reg_idx;
    logic [15:0]      reg_data, mem_addr, mem_rdata, mem_wdata;
    logic             out_valid, out_last, done;
    logic [15:0]      out_data, drop_count;
    logic [CNT_W-1:0] fifo_count;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } word_t;

    word_t      sbQ[$];
    word_t      monWord;
    int         nChecks = 0;
    int         nFails  = 0;
    int         mCount;
    logic [7:0] mSeq;
    logic       mLost;
    logic       mCap;

    always #5 clk = ~clk;

    commit_trace_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .reg_wr(reg_wr), .reg_idx(reg_idx), .reg_data(reg_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .drop_count(drop_count), .fifo_count(fifo_count),
        .done(done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    // Consumer side: every accepted word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_word", {31'd0, out_valid}, 32'd0);
            end else begin
                monWord = sbQ.pop_front();
                checkOutput("stream_data", {16'd0, out_data}, {16'd0, monWord.data});
                checkOutput("stream_last", {31'd0, out_last}, {31'd0, monWord.last});
                if (monWord.last) mCount--;
            end
        end
    end

    task automatic clearInputs();
        @(posedge clk); #1;
        reg_wr = 0; reg_idx = 0; reg_data = 0; mem_rd = 0; mem_wr = 0;
        mem_addr = 0; mem_rdata = 0; mem_wdata = 0; halt = 0;
    endtask

    task automatic resetDut();
        @(posedge clk); #1;
        rst = 1;
        reg_wr = 0; reg_idx = 0; reg_data = 0; mem_rd = 0; mem_wr = 0;
        mem_addr = 0; mem_rdata = 0; mem_wdata = 0; halt = 0;
        sbQ.delete();
        mCount = 0; mSeq = 0; mLost = 0; mCap = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    // Drives one cycle of commit inputs and predicts the resulting record words.
    task automatic applyStimulus(input logic rw, input logic [2:0] idx, input logic [15:0] rdat,
                                 input logic mr, input logic mw, input logic [15:0] addr,
                                 input logic [15:0] rdv, input logic [15:0] wdv, input logic h);
        logic [15:0] hdr;
        logic        hasMem;
        @(posedge clk); #1;
        reg_wr = rw; reg_idx = idx; reg_data = rdat; mem_rd = mr; mem_wr = mw;
        mem_addr = addr; mem_rdata = rdv; mem_wdata = wdv; halt = h;
        hasMem = mr | mw;
        if (mCap && (rw || mr || mw || h)) begin
            if (mCount >= DEPTH) begin
                mLost = 1;
            end else begin
                hdr = {h, mw, mr & ~mw, rw, rw ? idx : 3'd0, mLost, mSeq};
                sbQ.push_back({hdr, !rw && !hasMem});
                if (rw) sbQ.push_back({rdat, !hasMem});
                if (hasMem) begin
                    sbQ.push_back({addr, 1'b0});
                    sbQ.push_back({mw ? wdv : rdv, 1'b1});
                end
                mCount++;
                mSeq  = mSeq + 8'd1;
                mLost = 0;
            end
            if (h) mCap = 0;
        end
    endtask

    task automatic waitDrain(input string tag);
        int k = 0;
        while ((sbQ.size() != 0 || fifo_count != 0 || out_valid) && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_drain_in_time"}, {31'd0, (k < 300)}, 32'd1);
        checkOutput({tag, "_fifo_count"}, {28'd0, fifo_count}, 32'd0);
    endtask

    task automatic waitValid(input string tag);
        int k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_valid_in_time"}, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        rst = 1; out_ready = 0;
        reg_wr = 0; reg_idx = 0; reg_data = 0; mem_rd = 0; mem_wr = 0;
        mem_addr = 0; mem_rdata = 0; mem_wdata = 0; halt = 0;
        mCount = 0; mSeq = 0; mLost = 0; mCap = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checkOutput("rst_out_valid",  {31'd0, out_valid},  32'd0);
        checkOutput("rst_out_data",   {16'd0, out_data},   32'd0);
        checkOutput("rst_out_last",   {31'd0, out_last},   32'd0);
        checkOutput("rst_drop_count", {16'd0, drop_count}, 32'd0);
        checkOutput("rst_fifo_count", {28'd0, fifo_count}, 32'd0);
        checkOutput("rst_done",       {31'd0, done},       32'd0);

        $display("[TB] register write only");
        out_ready = 1;
        applyStimulus(1, 3'd3, 16'h1234, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        clearInputs();
        waitDrain("regwr");

        $display("[TB] store");
        resetDut();
        out_ready = 1;
        applyStimulus(0, 3'd0, 16'h0, 0, 1, 16'h0040, 16'h0, 16'hBEEF, 0);
        clearInputs();
        waitDrain("store");

        $display("[TB] load with writeback, then load+store together");
        resetDut();
        out_ready = 1;
        applyStimulus(1, 3'd1, 16'h00AA, 1, 0, 16'h0010, 16'h00AA, 16'h0, 0);
        applyStimulus(0, 3'd6, 16'h7777, 1, 1, 16'h0123, 16'h1111, 16'h2222, 0);
        clearInputs();
        waitDrain("load");

        $display("[TB] backpressure and overflow");
        resetDut();
        out_ready = 0;
        for (int i = 0; i < 10; i++)
            applyStimulus(1, i[2:0], 16'h0100 + 16'(i), 0, 0, 16'h0, 16'h0, 16'h0, 0);
        clearInputs();
        @(negedge clk);
        checkOutput("ovf_fifo_count", {28'd0, fifo_count}, 32'd8);
        checkOutput("ovf_drop_count", {16'd0, drop_count}, 32'd2);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stall_data",  {16'd0, out_data},  {16'd0, sbQ[0].data});
            checkOutput("stall_last",  {31'd0, out_last},  32'd0);
        end
        @(posedge clk); #1 out_ready = 1;
        begin
            int k = 0;
            while (fifo_count == 4'd8 && k < 50) begin
                @(negedge clk);
                k++;
            end
            checkOutput("ovf_first_pop_in_time", {31'd0, (k < 50)}, 32'd1);
        end
        applyStimulus(1, 3'd7, 16'h0ABC, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        clearInputs();
        waitDrain("ovf");
        checkOutput("ovf_drop_count_final", {16'd0, drop_count}, 32'd2);

        $display("[TB] reset mid-record");
        resetDut();
        out_ready = 0;
        applyStimulus(1, 3'd5, 16'hCAFE, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        clearInputs();
        waitValid("midrst");
        checkOutput("midrst_hdr", {16'd0, out_data}, 32'h1A00);
        @(posedge clk); #1 out_ready = 1;
        @(posedge clk); #1 out_ready = 0;
        @(negedge clk);
        checkOutput("midrst_regd", {16'd0, out_data}, 32'hCAFE);
        resetDut();
        @(negedge clk);
        checkOutput("midrst_valid",      {31'd0, out_valid},  32'd0);
        checkOutput("midrst_fifo_count", {28'd0, fifo_count}, 32'd0);
        checkOutput("midrst_drop_count", {16'd0, drop_count}, 32'd0);
        out_ready = 1;
        applyStimulus(1, 3'd0, 16'h0001, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        clearInputs();
        waitDrain("midrst");

        $display("[TB] halt");
        resetDut();
        out_ready = 1;
        applyStimulus(1, 3'd2, 16'h5555, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        applyStimulus(0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 1);
        clearInputs();
        begin
            int k = 0;
            while (!(out_valid && out_data == 16'h8001) && k < 50) begin
                @(negedge clk);
                k++;
            end
            checkOutput("halt_word_seen", {31'd0, (k < 50)}, 32'd1);
        end
        checkOutput("halt_done_before", {31'd0, done}, 32'd0);
        @(negedge clk);
        checkOutput("halt_done_after", {31'd0, done}, 32'd1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 3'd4, 16'h9999, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        clearInputs();
        repeat (5) @(negedge clk);
        checkOutput("halt_no_words",   {31'd0, out_valid},  32'd0);
        checkOutput("halt_no_drops",   {16'd0, drop_count}, 32'd0);
        checkOutput("halt_fifo_empty", {28'd0, fifo_count}, 32'd0);
        checkOutput("halt_done_hold",  {31'd0, done},       32'd1);
        checkOutput("halt_queue_empty", sbQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
